// File: rtl/shift_add_multiplier_4.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier_4
// Sequential 4x4 unsigned multiplier using the classic shift-and-add method.
// One partial product is added and shifted per clock, so a result takes four
// RUN cycles. A single 4-bit ripple-carry adder does all of the arithmetic.
//
// Ports
//   i_clk    sole clock, rising edge
//   i_rst    asynchronous active-high reset
//   i_start  request a multiply of i_a by i_b (honoured in IDLE or DONE only)
//   i_a      multiplicand, unsigned 4b
//   i_b      multiplier, unsigned 4b
//   o_busy   high while the FSM is in RUN
//   o_done   one-cycle pulse; o_p holds the new product in that cycle
//   o_p      registered 8b product, held until the next result is loaded
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for i_start
// RUN   | one add/shift step per edge, four steps total
// DONE  | result just loaded into o_p; i_start here chains the next operation
// ---------------------------------------------------------------------------

// 4-bit ripple-carry adder used for each partial-product accumulation.
//   i_a, i_b     addends
//   i_carry_in   carry into bit 0
//   o_s          4-bit sum
//   o_carry_out  carry out of bit 3
module ripple_carry_adder_4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_carry_in,
    output logic [3:0] o_s,
    output logic       o_carry_out
);
    logic [4:0] carry;

    assign carry[0] = i_carry_in;

    for (genvar g = 0; g < 4; g++) begin : g_fa
        assign o_s[g]       = i_a[g] ^ i_b[g] ^ carry[g];
        assign carry[g + 1] = (i_a[g] & i_b[g]) | (carry[g] & (i_a[g] ^ i_b[g]));
    end

    assign o_carry_out = carry[4];
endmodule

module shift_add_multiplier_4 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_p
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] mcand;
    logic [3:0] acc;
    logic [3:0] low;
    logic [1:0] cnt;

    logic [3:0] addend;
    logic [3:0] sum;
    logic       carry;

    // Adding zero when the current multiplier bit is clear keeps a single
    // datapath: the carry is then guaranteed 0 and sum == acc.
    assign addend = low[0] ? mcand : 4'd0;

    ripple_carry_adder_4 u_adder (
        .i_a         (acc),
        .i_b         (addend),
        .i_carry_in  (1'b0),
        .o_s         (sum),
        .o_carry_out (carry)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= IDLE;
            mcand  <= 4'd0;
            acc    <= 4'd0;
            low    <= 4'd0;
            cnt    <= 2'd0;
            o_p    <= 8'h00;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        mcand  <= i_a;
                        low    <= i_b;
                        acc    <= 4'd0;
                        cnt    <= 2'd0;
                        state  <= RUN;
                        o_busy <= 1'b1;
                        o_done <= 1'b0;
                    end else begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                        o_done <= 1'b0;
                    end
                end

                RUN: begin
                    // {carry, sum, low} shifted right by one into {acc, low};
                    // the low nibble fills with product bits as the multiplier
                    // bits are consumed.
                    acc <= {carry, sum[3:1]};
                    low <= {sum[0], low[3:1]};
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state  <= DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        o_p    <= {carry, sum, low[3:1]};
                    end
                end

                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                    o_done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_add_multiplier_4.sv
module tb_shift_add_multiplier_4;
    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] ia;
    logic [3:0] ib;
    logic       busy;
    logic       done;
    logic [7:0] p;

    int checks = 0;
    int errors = 0;

    // Last product the reference expects o_p to be holding.
    logic [7:0] model_p;

    shift_add_multiplier_4 dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_a     (ia),
        .i_b     (ib),
        .o_busy  (busy),
        .o_done  (done),
        .o_p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_mult(input logic [3:0] a, input logic [3:0] b);
        return 8'(a) * 8'(b);
    endfunction

    // Called at a negedge: presents a start request, returns at the negedge
    // following the start edge.
    task automatic issue(input logic [3:0] a, input logic [3:0] b);
        start = 1'b1;
        ia    = a;
        ib    = b;
        @(negedge clk);
    endtask

    // Follows an operation from the negedge after its start edge through
    // the DONE cycle. With noise, operands and i_start are scrambled during
    // RUN, which must not alter the result or timing.
    task automatic track(input logic [7:0] exp_p, input logic [7:0] prev_p, input bit noise);
        for (int k = 0; k < 4; k++) begin
            chk("busy_run", {7'd0, busy}, 8'd1);
            chk("done_run", {7'd0, done}, 8'd0);
            chk("p_held_run", p, prev_p);
            if (noise) begin
                start = 1'($urandom);
                ia    = 4'($urandom);
                ib    = 4'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_pulse", {7'd0, done}, 8'd1);
        chk("busy_done", {7'd0, busy}, 8'd0);
        chk("product", p, exp_p);
        model_p = exp_p;
    endtask

    task automatic check_idle();
        @(negedge clk);
        chk("idle_busy", {7'd0, busy}, 8'd0);
        chk("idle_done", {7'd0, done}, 8'd0);
        chk("idle_p_held", p, model_p);
    endtask

    task automatic one_op(input logic [3:0] a, input logic [3:0] b, input bit noise);
        logic [7:0] prev;
        prev = model_p;
        issue(a, b);
        track(ref_mult(a, b), prev, noise);
        check_idle();
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        ia      = 4'd0;
        ib      = 4'd0;
        model_p = 8'h00;

        #2;
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_p", p, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed operands
        one_op(4'd10, 4'd1, 1'b0);
        one_op(4'd15, 4'd15, 1'b0);
        one_op(4'd7, 4'd12, 1'b0);
        one_op(4'd0, 4'd9, 1'b0);
        one_op(4'd3, 4'd5, 1'b1);

        // Back-to-back: i_start held across DONE with new operands
        @(negedge clk);
        issue(4'd3, 4'd6);
        track(8'd18, model_p, 1'b0);
        issue(4'd6, 4'd6);
        track(8'd36, 8'd18, 1'b0);
        check_idle();

        // Asynchronous reset during the second step of 15*15
        @(negedge clk);
        issue(4'd15, 4'd15);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", {7'd0, busy}, 8'd0);
        chk("async_rst_done", {7'd0, done}, 8'd0);
        chk("async_rst_p", p, 8'h00);
        start = 1'b0;
        model_p = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("no_done_after_rst", {7'd0, done}, 8'd0);
            chk("p_zero_after_rst", p, 8'h00);
        end
        issue(4'd2, 4'd3);
        track(8'd6, 8'h00, 1'b0);
        check_idle();

        // Exhaustive sweep with random RUN noise and random idle gaps
        for (int i = 0; i < 256; i++) begin
            one_op(4'(i >> 4), 4'(i), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Extra random operations
        for (int i = 0; i < 40; i++)
            one_op(4'($urandom), 4'($urandom), 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_add_multiplier_4.md
SHIFT_ADD_MULTIPLIER_4 -- requirements
Module: shift_add_multiplier_4

Interface
REQ-001 Parameters: none; operand width fixed at 4 bits, product width at 8 bits.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset, asynchronous, active-high.
REQ-004 i_start  input  1  request to multiply i_a by i_b.
REQ-005 i_a  input  4  multiplicand, unsigned.
REQ-006 i_b  input  4  multiplier, unsigned.
REQ-007 o_busy  output  1  high while a multiplication is in progress.
REQ-008 o_done  output  1  one-cycle pulse marking o_p as the new result.
REQ-009 o_p  output  8  registered unsigned product.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-011 The block SHALL hold state: multiplicand reg (4b), accumulator reg (4b), multiplier/low-product reg (4b), step counter (2b), result reg (8b).
REQ-012 In IDLE or DONE, i_start=1 at a rising edge SHALL:
- latch i_a into the multiplicand reg and i_b into the low-product reg;
- clear the accumulator and counter;
- enter RUN.
REQ-013 i_a and i_b SHALL be sampled only at the start edge; changes during RUN SHALL have no effect.
REQ-014 i_start during RUN SHALL be ignored, with no restart and no queuing.
REQ-015 Each RUN edge SHALL perform one step:
- if low-product bit 0 = 1: {c, acc} = acc + multiplicand (carry-in 0), else {c, acc} = {0, acc};
- then shift {c, acc, low} right by one bit into {acc, low}.
REQ-016 The step addition SHALL use one instance of the existing ripple_carry_adder_4 (i_a, i_b, i_carry_in=0, o_s, o_carry_out). No "*" operator is permitted.
REQ-017 After the 4th RUN step (counter wrap 3->0), the FSM SHALL:
- enter DONE;
- load o_p with {acc, low} from that same edge.
REQ-018 Latency: for a start sampled at edge t, o_done SHALL be high in exactly the cycle following edge t+4, with o_p valid from that edge.
REQ-019 o_busy SHALL equal (state == RUN); o_done SHALL equal (state == DONE).
REQ-020 From DONE without i_start, the FSM SHALL return to IDLE at the next edge. From DONE with i_start, it SHALL go to RUN (back-to-back operation).
REQ-021 o_p SHALL hold its last result through IDLE and RUN until the next DONE load.
REQ-022 Products SHALL be exact over the full range (max 15*15 = 225 = 8'hE1); no overflow is possible.

Reset
REQ-023 i_rst=1 SHALL immediately, without waiting for a clock edge:
- force state to IDLE;
- set o_busy=0, o_done=0, o_p=8'h00;
- clear every internal register.
REQ-024 A reset asserted mid-RUN SHALL abort the operation; no o_done pulse shall follow; o_p shall read 0.
REQ-025 After i_rst is released, the first rising edge with i_start=1 SHALL start a fresh operation.

Verification
REQ-026 Start with a=4'd10, b=4'd1 -> o_busy high for 4 cycles, then o_done for 1 cycle with o_p=8'd10; then IDLE with o_p held.
REQ-027 Start a=15, b=15 -> o_p=8'hE1; start a=7, b=12 -> o_p=8'h54; start a=0, b=9 -> o_p=8'h00. Each o_done arrives exactly 4 cycles after the start edge.
REQ-028 Start a=3, b=5; change i_a/i_b and pulse i_start during RUN -> result 8'd15, done timing unchanged, no second operation.
REQ-029 i_start held high across DONE with new operands a=6, b=6 -> immediate re-entry to RUN, next o_done with o_p=8'd36, and o_p=8'd18 from the prior a=3, b=6 held meanwhile.
REQ-030 Assert i_rst asynchronously (between edges) during step 2 of a=15, b=15 -> outputs go to 0 before the next edge, and no o_done occurs. A subsequent a=2, b=3 gives o_p=8'd6.
REQ-031 Exhaustive sweep of all 256 operand pairs against a reference product -> zero mismatches.
